rf_write_arbiter: RTL

//  Shares the register file's single write port (WE3/WA3/WD3) between NREQ

---
 rtl/rf_write_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Round-robin arbiter sharing the register file's single write
//                port between NREQ write-back requesters. The granted write is
//                registered onto rf_we/rf_wa/rf_wd. The module also keeps a
//                per-register busy scoreboard and a saturating count of
//                committed writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int BITS = 16,
  parameter int N    = 3,
  parameter int NREQ = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hold,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*N-1:0]      req_addr,
  input  logic [NREQ*BITS-1:0]   req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   issue_valid,
  input  logic [N-1:0]           issue_addr,
  output logic [(1<<N)-1:0]      busy,
  output logic                   rf_we,
  output logic [N-1:0]           rf_wa,
  output logic [BITS-1:0]        rf_wd,
  output logic [15:0]            wr_count
);

  localparam int              c_PTR_W    = $clog2(NREQ);
  localparam int              c_NUM_REGS = 1 << N;
  localparam logic [c_PTR_W:0] c_NREQ_EXT = (c_PTR_W + 1)'(NREQ);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(NREQ - 1);

  // Registered state
  logic [c_PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                  rf_we_q;
  logic [N-1:0]          rf_wa_q;
  logic [BITS-1:0]       rf_wd_q;
  logic [c_NUM_REGS-1:0] busy_q, busy_d;
  logic [15:0]           wr_count_q, wr_count_d;

  // Arbitration wires
  logic [c_PTR_W:0]      w_cand;
  logic [c_PTR_W-1:0]    w_grant_idx;
  logic                  w_grant_any;
  logic [N-1:0]          w_sel_addr;
  logic [BITS-1:0]       w_sel_data;

  // Scan requesters starting at rr_ptr (wrapping) and pick the first valid one.
  always_comb begin
    w_cand      = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    if (!hold) begin
      for (int i = 0; i < NREQ; i++) begin
        w_cand = {1'b0, rr_ptr_q} + (c_PTR_W + 1)'(i);
        if (w_cand >= c_NREQ_EXT) begin
          w_cand = w_cand - c_NREQ_EXT;
        end
        if (!w_grant_any && req_valid[w_cand[c_PTR_W-1:0]]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_cand[c_PTR_W-1:0];
        end
      end
    end
  end

  // One-hot ready plus the winner's address/data; ready only ever lands on a
  // valid requester, so ready alone marks the handshake.
  always_comb begin
    req_ready  = '0;
    w_sel_addr = req_addr[w_grant_idx*N +: N];
    w_sel_data = req_data[w_grant_idx*BITS +: BITS];
    if (w_grant_any) begin
      req_ready[w_grant_idx] = 1'b1;
    end
  end

  // Pointer moves just past the winner; it stays put when nothing is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_grant_any) begin
      rr_ptr_d = (w_grant_idx == c_LAST) ? '0 : w_grant_idx + c_PTR_W'(1);
    end
  end

  // Scoreboard: the write leaving the output stage clears, a new issue sets;
  // set is applied last so a newer writer to the same reg wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_wa_q] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  // Committed-write counter saturating at all-ones.
  always_comb begin
    wr_count_d = wr_count_q;
    if (rf_we_q && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // State registers; async reset drops any write sitting in the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wd_q    <= '0;
      busy_q     <= '0;
      wr_count_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= w_grant_any;
      if (w_grant_any) begin
        rf_wa_q <= w_sel_addr;
        rf_wd_q <= w_sel_data;
      end
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wd    = rf_wd_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule
`default_nettype wire
